// File: rtl/uart_tx_con.sv
// uart_tx_con - UART transmit controller.
//
// Serialises one byte per accepted request into an 8N1 frame on oUART_TX:
// a low start bit, eight data bits LSB first, then a high stop bit. Every
// bit lasts BAUD_PERIOD_COUNT clocks, timed by an internal period counter.
// A byte is accepted when iTX_VALID and oTX_READY are both high, and
// oTX_READY is only high while the controller is idle.
//
// Optional feature: define UART_TX_PARITY_EN to add a parity bit between
// the last data bit and the stop bit (frame becomes 8E1 or 8O1). Parity
// sense is chosen by the PARITY_ODD parameter, which only exists when the
// macro is defined.

module uart_tx_con #(
  parameter int CLOCK_PERIOD      = 10_000_000,
  parameter int BAUD_RATE         = 115_200,
  parameter int BAUD_PERIOD_COUNT = CLOCK_PERIOD / BAUD_RATE
`ifdef UART_TX_PARITY_EN
  ,
  parameter bit PARITY_ODD        = 1'b0
`endif
) (
  input  logic       iCLK,
  input  logic       iRESET,
  input  logic       iTX_VALID,
  input  logic [7:0] iTX_DATA,
  output logic       oTX_READY,
  output logic       oUART_TX,
  output logic       oUART_TX_BUSY,
  output logic       oUART_TX_DONE
);

  // The period counter must hold 0..BAUD_PERIOD_COUNT-1; keep at least one bit.
  localparam int CntWidth = (BAUD_PERIOD_COUNT > 2) ? $clog2(BAUD_PERIOD_COUNT) : 1;
  localparam logic [CntWidth-1:0] LastCount = CntWidth'(BAUD_PERIOD_COUNT - 1);

  // PARITY is only ever entered when the parity feature is built in; in the
  // plain 8N1 build it behaves like any other unused encoding.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } txState_t;

  txState_t              state;
  logic [CntWidth-1:0]   periodCnt;
  logic [2:0]            bitCnt;
  logic [7:0]            shiftReg;
  logic                  periodWrap;
  logic                  accept;
`ifdef UART_TX_PARITY_EN
  logic                  parityBit;
`endif

  assign periodWrap = (periodCnt == LastCount);
  assign accept     = iTX_VALID & oTX_READY;

  // Frame sequencer: state, counters, shift register and all registered outputs.
  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      state         <= IDLE;
      periodCnt     <= '0;
      bitCnt        <= 3'd0;
      shiftReg      <= 8'h00;
      oUART_TX      <= 1'b1;
      oTX_READY     <= 1'b1;
      oUART_TX_BUSY <= 1'b0;
      oUART_TX_DONE <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parityBit     <= 1'b0;
`endif
    end else begin
      oUART_TX_DONE <= 1'b0;
      case (state)
        IDLE: begin
          periodCnt     <= '0;
          bitCnt        <= 3'd0;
          oUART_TX      <= 1'b1;
          oTX_READY     <= 1'b1;
          oUART_TX_BUSY <= 1'b0;
          if (accept) begin
            state         <= START;
            shiftReg      <= iTX_DATA;
            oUART_TX      <= 1'b0;
            oTX_READY     <= 1'b0;
            oUART_TX_BUSY <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parityBit     <= PARITY_ODD ? ~^iTX_DATA : ^iTX_DATA;
`endif
          end
        end

        START: begin
          if (periodWrap) begin
            periodCnt <= '0;
            state     <= DATA;
            oUART_TX  <= shiftReg[0];
          end else begin
            periodCnt <= periodCnt + CntWidth'(1);
          end
        end

        DATA: begin
          if (periodWrap) begin
            periodCnt <= '0;
            bitCnt    <= bitCnt + 3'd1;
            if (bitCnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state    <= PARITY;
              oUART_TX <= parityBit;
`else
              state    <= STOP;
              oUART_TX <= 1'b1;
`endif
            end else begin
              shiftReg <= shiftReg >> 1;
              oUART_TX <= shiftReg[1];
            end
          end else begin
            periodCnt <= periodCnt + CntWidth'(1);
          end
        end

`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (periodWrap) begin
            periodCnt <= '0;
            state     <= STOP;
            oUART_TX  <= 1'b1;
          end else begin
            periodCnt <= periodCnt + CntWidth'(1);
          end
        end
`endif

        STOP: begin
          if (periodWrap) begin
            periodCnt     <= '0;
            state         <= IDLE;
            oUART_TX      <= 1'b1;
            oTX_READY     <= 1'b1;
            oUART_TX_BUSY <= 1'b0;
            oUART_TX_DONE <= 1'b1;
          end else begin
            periodCnt <= periodCnt + CntWidth'(1);
          end
        end

        default: begin
          state         <= IDLE;
          periodCnt     <= '0;
          bitCnt        <= 3'd0;
          oUART_TX      <= 1'b1;
          oTX_READY     <= 1'b1;
          oUART_TX_BUSY <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_con.sv
// tb_uart_tx_con - self-checking bench for uart_tx_con with N = 16 clocks/bit.
// A line monitor decodes every frame and compares it against a queue of
// expected bytes; each scenario task also checks cycle-exact behaviour.
// Define UART_TX_PARITY_EN to exercise the parity build (even and odd).

module tb_uart_tx_con;

  localparam int N = 16;
`ifdef UART_TX_PARITY_EN
  localparam int FrameBits = 11;
`else
  localparam int FrameBits = 10;
`endif
  localparam int FramePeriod = FrameBits * N + 1;

  logic       iCLK;
  logic       iRESET;
  logic       iTX_VALID;
  logic [7:0] iTX_DATA;
  logic       oTX_READY;
  logic       oUART_TX;
  logic       oUART_TX_BUSY;
  logic       oUART_TX_DONE;

  int         checks;
  int         failures;
  logic [7:0] expQ[$];

  uart_tx_con #(
    .CLOCK_PERIOD (1600),
    .BAUD_RATE    (100)
`ifdef UART_TX_PARITY_EN
    ,
    .PARITY_ODD   (1'b0)
`endif
  ) dut (
    .iCLK          (iCLK),
    .iRESET        (iRESET),
    .iTX_VALID     (iTX_VALID),
    .iTX_DATA      (iTX_DATA),
    .oTX_READY     (oTX_READY),
    .oUART_TX      (oUART_TX),
    .oUART_TX_BUSY (oUART_TX_BUSY),
    .oUART_TX_DONE (oUART_TX_DONE)
  );

`ifdef UART_TX_PARITY_EN
  logic oddReady;
  logic oddTx;
  logic oddBusy;
  logic oddDone;

  uart_tx_con #(
    .CLOCK_PERIOD (1600),
    .BAUD_RATE    (100),
    .PARITY_ODD   (1'b1)
  ) dutOdd (
    .iCLK          (iCLK),
    .iRESET        (iRESET),
    .iTX_VALID     (iTX_VALID),
    .iTX_DATA      (iTX_DATA),
    .oTX_READY     (oddReady),
    .oUART_TX      (oddTx),
    .oUART_TX_BUSY (oddBusy),
    .oUART_TX_DONE (oddDone)
  );
`endif

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  // Line monitor: finds each start bit, samples mid-bit, and scores the byte at the stop bit.
  initial begin
    logic       monActive;
    int         monCnt;
    int         bitIdx;
    logic [7:0] monByte;
    logic [7:0] expByte;
    logic       monParity;
    monActive = 1'b0;
    monCnt    = 0;
    monByte   = 8'h00;
    monParity = 1'b0;
    forever begin
      @(negedge iCLK);
      if (iRESET) begin
        monActive = 1'b0;
      end else if (!monActive) begin
        if (oUART_TX === 1'b0) begin
          monActive = 1'b1;
          monCnt    = 1;
        end
      end else begin
        monCnt++;
        if ((monCnt % N) == (N / 2)) begin
          bitIdx = monCnt / N;
          if (bitIdx == 0) begin
            checks++;
            if (oUART_TX !== 1'b0) begin
              failures++;
              $display("[TB] FAIL monitor start bit: got %b expected 0", oUART_TX);
            end
          end else if (bitIdx <= 8) begin
            monByte[bitIdx-1] = oUART_TX;
          end else if (bitIdx < FrameBits - 1) begin
            monParity = oUART_TX;
          end else begin
            checks++;
            if (oUART_TX !== 1'b1) begin
              failures++;
              $display("[TB] FAIL monitor stop bit: got %b expected 1", oUART_TX);
            end
            checks++;
            if (expQ.size() == 0) begin
              failures++;
              $display("[TB] FAIL monitor unexpected frame: got %h expected none", monByte);
            end else begin
              expByte = expQ.pop_front();
              if (monByte !== expByte) begin
                failures++;
                $display("[TB] FAIL monitor byte: got %h expected %h", monByte, expByte);
              end
`ifdef UART_TX_PARITY_EN
              checks++;
              if (monParity !== ^expByte) begin
                failures++;
                $display("[TB] FAIL monitor parity: got %b expected %b", monParity, ^expByte);
              end
`endif
            end
          end
        end
        if (monCnt == FrameBits * N) monActive = 1'b0;
      end
    end
  end

  task automatic test_reset();
    iRESET    = 1'b1;
    iTX_VALID = 1'b0;
    iTX_DATA  = 8'h00;
    repeat (2) @(negedge iCLK);
    checks++;
    if (oUART_TX !== 1'b1) begin failures++; $display("[TB] FAIL reset tx: got %b expected 1", oUART_TX); end
    checks++;
    if (oTX_READY !== 1'b1) begin failures++; $display("[TB] FAIL reset ready: got %b expected 1", oTX_READY); end
    checks++;
    if (oUART_TX_BUSY !== 1'b0) begin failures++; $display("[TB] FAIL reset busy: got %b expected 0", oUART_TX_BUSY); end
    checks++;
    if (oUART_TX_DONE !== 1'b0) begin failures++; $display("[TB] FAIL reset done: got %b expected 0", oUART_TX_DONE); end
    iRESET = 1'b0;
    repeat (2) @(negedge iCLK);
    checks++;
    if (oTX_READY !== 1'b1 || oUART_TX !== 1'b1) begin
      failures++;
      $display("[TB] FAIL post-reset idle: got ready=%b tx=%b expected ready=1 tx=1", oTX_READY, oUART_TX);
    end
  endtask

  task automatic test_single_frame();
    logic [7:0] d;
    logic       expTx;
    logic       expBusy;
    logic       expEnd;
    d = 8'hA5;
    @(negedge iCLK);
    iTX_VALID = 1'b1;
    iTX_DATA  = d;
    expQ.push_back(d);
    @(posedge iCLK);
    #1 iTX_VALID = 1'b0;
    for (int c = 1; c <= FramePeriod; c++) begin
      @(negedge iCLK);
      if (c <= N) expTx = 1'b0;
      else if (c <= 9 * N) expTx = d[(c - 1) / N - 1];
`ifdef UART_TX_PARITY_EN
      else if (c <= 10 * N) expTx = ^d;
`endif
      else expTx = 1'b1;
      expBusy = (c <= FrameBits * N);
      expEnd  = (c == FramePeriod);
      checks++;
      if (oUART_TX !== expTx) begin
        failures++;
        $display("[TB] FAIL single_frame tx cycle %0d: got %b expected %b", c, oUART_TX, expTx);
      end
      checks++;
      if (oUART_TX_BUSY !== expBusy) begin
        failures++;
        $display("[TB] FAIL single_frame busy cycle %0d: got %b expected %b", c, oUART_TX_BUSY, expBusy);
      end
      checks++;
      if (oUART_TX_DONE !== expEnd) begin
        failures++;
        $display("[TB] FAIL single_frame done cycle %0d: got %b expected %b", c, oUART_TX_DONE, expEnd);
      end
      checks++;
      if (oTX_READY !== expEnd) begin
        failures++;
        $display("[TB] FAIL single_frame ready cycle %0d: got %b expected %b", c, oTX_READY, expEnd);
      end
    end
  endtask

  task automatic test_back_to_back();
    int doneCount;
    doneCount = 0;
    @(negedge iCLK);
    iTX_VALID = 1'b1;
    iTX_DATA  = 8'h00;
    expQ.push_back(8'h00);
    @(posedge iCLK);
    #1 iTX_DATA = 8'hFF;
    expQ.push_back(8'hFF);
    for (int c = 1; c <= 2 * FramePeriod + 1; c++) begin
      @(negedge iCLK);
      if (oUART_TX_DONE === 1'b1) doneCount++;
      if (c == FramePeriod) begin
        checks++;
        if (oUART_TX !== 1'b1 || oTX_READY !== 1'b1 || oUART_TX_DONE !== 1'b1) begin
          failures++;
          $display("[TB] FAIL b2b gap cycle: got tx=%b ready=%b done=%b expected 1/1/1", oUART_TX, oTX_READY, oUART_TX_DONE);
        end
      end
      if (c == FramePeriod + 1) begin
        checks++;
        if (oUART_TX !== 1'b0 || oUART_TX_BUSY !== 1'b1) begin
          failures++;
          $display("[TB] FAIL b2b second start: got tx=%b busy=%b expected 0/1", oUART_TX, oUART_TX_BUSY);
        end
        iTX_VALID = 1'b0;
      end
      if (c == 2 * FramePeriod) begin
        checks++;
        if (oUART_TX_DONE !== 1'b1) begin
          failures++;
          $display("[TB] FAIL b2b second done: got %b expected 1", oUART_TX_DONE);
        end
      end
    end
    checks++;
    if (doneCount != 2) begin
      failures++;
      $display("[TB] FAIL b2b done count: got %0d expected 2", doneCount);
    end
    checks++;
    if (oUART_TX_BUSY !== 1'b0 || oUART_TX !== 1'b1) begin
      failures++;
      $display("[TB] FAIL b2b final idle: got busy=%b tx=%b expected 0/1", oUART_TX_BUSY, oUART_TX);
    end
  endtask

  task automatic test_busy_ignore();
    int doneCount;
    doneCount = 0;
    @(negedge iCLK);
    iTX_VALID = 1'b1;
    iTX_DATA  = 8'h55;
    expQ.push_back(8'h55);
    @(posedge iCLK);
    #1 iTX_VALID = 1'b0;
    for (int c = 1; c <= FramePeriod + 2 * N; c++) begin
      @(negedge iCLK);
      if (oUART_TX_DONE === 1'b1) doneCount++;
      if (c == 50) begin
        checks++;
        if (oTX_READY !== 1'b0) begin
          failures++;
          $display("[TB] FAIL busy_ignore ready mid-frame: got %b expected 0", oTX_READY);
        end
        iTX_VALID = 1'b1;
        iTX_DATA  = 8'h3C;
      end
      if (c == 51) iTX_VALID = 1'b0;
      if (c == FramePeriod) begin
        checks++;
        if (oUART_TX_DONE !== 1'b1) begin
          failures++;
          $display("[TB] FAIL busy_ignore done: got %b expected 1", oUART_TX_DONE);
        end
      end
    end
    checks++;
    if (doneCount != 1) begin
      failures++;
      $display("[TB] FAIL busy_ignore done count: got %0d expected 1", doneCount);
    end
    checks++;
    if (oUART_TX_BUSY !== 1'b0 || oUART_TX !== 1'b1) begin
      failures++;
      $display("[TB] FAIL busy_ignore trailing idle: got busy=%b tx=%b expected 0/1", oUART_TX_BUSY, oUART_TX);
    end
  endtask

  task automatic test_reset_midframe();
    @(negedge iCLK);
    iTX_VALID = 1'b1;
    iTX_DATA  = 8'hC3;
    expQ.push_back(8'hC3);
    @(posedge iCLK);
    #1 iTX_VALID = 1'b0;
    for (int c = 1; c < 70; c++) @(negedge iCLK);
    @(negedge iCLK);
    checks++;
    if (oUART_TX !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_midframe pre-reset tx: got %b expected 0", oUART_TX);
    end
    iRESET = 1'b1;
    expQ.delete();
    #1;
    checks++;
    if (oUART_TX !== 1'b1 || oUART_TX_BUSY !== 1'b0 || oTX_READY !== 1'b1 || oUART_TX_DONE !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_midframe outputs: got tx=%b busy=%b ready=%b done=%b expected 1/0/1/0",
               oUART_TX, oUART_TX_BUSY, oTX_READY, oUART_TX_DONE);
    end
    repeat (2) @(negedge iCLK);
    iRESET    = 1'b0;
    iTX_VALID = 1'b1;
    iTX_DATA  = 8'h81;
    expQ.push_back(8'h81);
    @(posedge iCLK);
    #1 iTX_VALID = 1'b0;
    checks++;
    if (oUART_TX !== 1'b0 || oUART_TX_BUSY !== 1'b1 || oTX_READY !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_midframe first accept: got tx=%b busy=%b ready=%b expected 0/1/0",
               oUART_TX, oUART_TX_BUSY, oTX_READY);
    end
    for (int c = 1; c <= FramePeriod; c++) begin
      @(negedge iCLK);
      if (c == FramePeriod) begin
        checks++;
        if (oUART_TX_DONE !== 1'b1) begin
          failures++;
          $display("[TB] FAIL reset_midframe done: got %b expected 1", oUART_TX_DONE);
        end
      end
    end
  endtask

  task automatic test_data_change();
    @(negedge iCLK);
    iTX_VALID = 1'b1;
    iTX_DATA  = 8'h12;
    expQ.push_back(8'h12);
    @(posedge iCLK);
    #1 iTX_VALID = 1'b0;
    for (int c = 1; c <= FramePeriod; c++) begin
      @(negedge iCLK);
      iTX_DATA = 8'($urandom);
      if (c == FramePeriod) begin
        checks++;
        if (oUART_TX_DONE !== 1'b1 || oTX_READY !== 1'b1) begin
          failures++;
          $display("[TB] FAIL data_change end: got done=%b ready=%b expected 1/1", oUART_TX_DONE, oTX_READY);
        end
      end
    end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    @(negedge iCLK);
    iTX_VALID = 1'b1;
    iTX_DATA  = 8'h07;
    expQ.push_back(8'h07);
    @(posedge iCLK);
    #1 iTX_VALID = 1'b0;
    for (int c = 1; c <= FramePeriod; c++) begin
      @(negedge iCLK);
      if (c >= 145 && c <= 160) begin
        checks++;
        if (oUART_TX !== 1'b1 || oddTx !== 1'b0) begin
          failures++;
          $display("[TB] FAIL parity bit cycle %0d: got even=%b odd=%b expected 1/0", c, oUART_TX, oddTx);
        end
      end
      if (c >= 161 && c <= 176) begin
        checks++;
        if (oUART_TX !== 1'b1 || oddTx !== 1'b1) begin
          failures++;
          $display("[TB] FAIL parity stop cycle %0d: got even=%b odd=%b expected 1/1", c, oUART_TX, oddTx);
        end
      end
      if (c == 177) begin
        checks++;
        if (oUART_TX_DONE !== 1'b1 || oddDone !== 1'b1) begin
          failures++;
          $display("[TB] FAIL parity done: got even=%b odd=%b expected 1/1", oUART_TX_DONE, oddDone);
        end
      end
    end
  endtask
`endif

  // Scenario sequence followed by the scoreboard drain check and summary.
  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_single_frame();
    repeat (3) @(negedge iCLK);
    test_back_to_back();
    repeat (3) @(negedge iCLK);
    test_busy_ignore();
    repeat (3) @(negedge iCLK);
    test_reset_midframe();
    repeat (3) @(negedge iCLK);
    test_data_change();
    repeat (3) @(negedge iCLK);
`ifdef UART_TX_PARITY_EN
    test_parity();
    repeat (3) @(negedge iCLK);
`endif
    checks++;
    if (expQ.size() != 0) begin
      failures++;
      $display("[TB] FAIL scoreboard drain: got %0d pending expected 0", expQ.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
